gfib_stream: RTL and testbench
==============================

// Module: gfib_stream
// PURPOSE
//  Parametrised generalised-Fibonacci engine: T(0)=seed0, T(1)=seed1, T(k)=T(k-1)+T(k-2).
//  Computes T(n) on request. Streams every term T(0)..T(n) over a valid/ready port with backpressure.
//  Supports selectable wrap or saturate overflow handling, with a sticky overflow flag.
//  Second-generation lab2 calculator; standard Fibonacci is seed0=0, seed1=1 (T(10)=55).
// PARAMETERS
//  INPUT_WIDTH   6   bit width of n (max index 2**INPUT_WIDTH-1)
//  OUTPUT_WIDTH  32  bit width of seeds, terms and result
//  SATURATE      0   0: sums wrap mod 2**OUTPUT_WIDTH; 1: sums clamp to all-ones
// PORTS
//  clk         in   1             clock, all state on rising edge
//  rst         in   1             asynchronous reset, active-high
//  go          in   1             start request; sampled only in IDLE or DONE
//  n           in   INPUT_WIDTH   index of final term; sampled with accepted go
//  seed0       in   OUTPUT_WIDTH  T(0); sampled with accepted go
//  seed1       in   OUTPUT_WIDTH  T(1); sampled with accepted go
//  term        out  OUTPUT_WIDTH  current streamed term T(k)
//  term_valid  out  1             term is valid
//  term_ready  in   1             consumer accepts term when term_valid && term_ready
//  result      out  OUTPUT_WIDTH  T(n); valid while done=1
//  overflow    out  1             sticky: some generated T(k), k<=n, overflowed; valid with done
//  done        out  1             result/overflow valid; holds until the next accepted go
// BEHAVIOUR
//  Reset (async, any state incl. mid-run): state=IDLE; term, result='0; term_valid, overflow, done=0.
//  States: IDLE, EMIT, DONE.
//   - IDLE --go--> EMIT.
//   - EMIT --accept && k==n--> DONE.
//   - EMIT --accept && k<n--> EMIT (advance).
//   - DONE --go--> EMIT.
//  Accepted go (IDLE/DONE only):
//   - Latch n, seed0 and seed1.
//   - Set k=0, overflow=0, done=0.
//   - Next cycle: term=seed0, term_valid=1.
//  go during EMIT: ignored (no restart, no re-sample). Input changes during a run are also ignored.
//  EMIT: term_valid=1. term must hold stable until accepted; term_valid never drops before accept.
//  Accept T(k) with k<n:
//   - Next cycle term=T(k+1) and k increments.
//   - One term per cycle when term_ready is held high.
//   - T(1)=seed1 is passed through unchanged and never sets overflow.
//  Accept T(n):
//   - term_valid=0 next cycle.
//   - result=T(n) and done=1 on the same next cycle.
//  Latency, with term_ready held high: go at cycle 0 -> T(k) at cycle k+1 -> done at cycle n+2.
//  n=0: emits only seed0, and result=seed0. n=1: emits seed0 then seed1, and result=seed1.
//  Arithmetic:
//   - Each sum is formed OUTPUT_WIDTH+1 bits wide; the carry bit sets overflow (sticky).
//   - SATURATE=0: the term keeps the low OUTPUT_WIDTH bits.
//   - SATURATE=1: the term becomes all-ones, and later terms stay all-ones.
//   - Overflow is never raised by T(n+1); no term beyond n is computed.
//  done/result/overflow hold indefinitely in DONE. go in DONE clears done on the next cycle.
//  go and an accept in the same cycle: only possible outside EMIT, so go alone takes effect.
// TESTING
//  1. seed0=0, seed1=1, n=10, term_ready=1 -> stream 0,1,1,2,3,5,8,13,21,34,55; done at cycle 12; result=55; overflow=0.
//  2. seed0=2, seed1=1 (Lucas), n=5, term_ready toggled 1010.. -> terms 2,1,3,4,7,11 each held until accepted; result=11.
//  3. n=0 -> single term seed0, result=seed0. n=1 -> terms seed0, seed1, result=seed1.
//  4. OUTPUT_WIDTH=8, seed0=0, seed1=1: n=13 -> result=233, overflow=0.
//     n=14, SATURATE=0 -> result=121 (377 mod 256), overflow=1.
//     n=14, SATURATE=1 -> result=255, overflow=1.
//  5. go pulsed mid-stream with a new n -> ignored, original run completes.
//     go in DONE -> done=0 next cycle, new run starts, overflow cleared.
//  6. rst asserted mid-EMIT -> outputs zero immediately.
//     After release, go with n=3 -> correct 0,1,1,2 stream.

Source files
------------

// File: rtl/gfib_stream.sv
// ---------------------------------------------------------------------------
// gfib_stream
//   Generalised Fibonacci engine: T(0)=seed0, T(1)=seed1,
//   T(k)=T(k-1)+T(k-2). On an accepted go it streams T(0)..T(n) over a
//   valid/ready port, then presents T(n) on o_result with o_done held high.
//   Sums are formed one bit wider than the terms; the carry sets a sticky
//   overflow flag and either wraps (SATURATE=0) or clamps to all-ones
//   (SATURATE=1).
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   asynchronous reset, active-high
//   i_go           in   start request, honoured only in IDLE or DONE
//   i_n            in   index of final term, latched with accepted go
//   i_seed0        in   T(0), latched with accepted go
//   i_seed1        in   T(1), latched with accepted go
//   o_term         out  current streamed term T(k)
//   o_term_valid   out  o_term is valid
//   i_term_ready   in   consumer takes o_term when valid && ready
//   o_result       out  T(n), valid while o_done=1
//   o_overflow     out  sticky: some T(k), k<=n, overflowed
//   o_done         out  result/overflow valid until the next accepted go
// ---------------------------------------------------------------------------
module gfib_stream #(
    parameter int INPUT_WIDTH  = 6,
    parameter int OUTPUT_WIDTH = 32,
    parameter bit SATURATE     = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_go,
    input  logic [INPUT_WIDTH-1:0]  i_n,
    input  logic [OUTPUT_WIDTH-1:0] i_seed0,
    input  logic [OUTPUT_WIDTH-1:0] i_seed1,
    output logic [OUTPUT_WIDTH-1:0] o_term,
    output logic                    o_term_valid,
    input  logic                    i_term_ready,
    output logic [OUTPUT_WIDTH-1:0] o_result,
    output logic                    o_overflow,
    output logic                    o_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_go_acc;
    logic                    w_accept;
    logic                    w_last;

    logic [INPUT_WIDTH-1:0]  r_n;
    logic [INPUT_WIDTH-1:0]  r_k;
    // r_term holds T(k); r_prev holds T(k-1), except at k=0 where it
    // holds seed1 so the first advance is a plain pass-through.
    logic [OUTPUT_WIDTH-1:0] r_term;
    logic [OUTPUT_WIDTH-1:0] r_prev;
    logic                    r_term_valid;
    logic [OUTPUT_WIDTH-1:0] r_result;
    logic                    r_overflow;
    logic                    r_done;

    logic [OUTPUT_WIDTH:0]   w_sum;
    logic                    w_carry;
    logic [OUTPUT_WIDTH-1:0] w_next_term;
    logic                    w_next_ovf;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus go-accept / term-accept strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_go_acc    = 1'b0;
        w_accept    = 1'b0;
        w_last      = (r_k == r_n);
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_go) begin
                    w_state_nxt = S_EMIT;
                    w_go_acc    = 1'b1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_EMIT: begin
                if (i_term_ready) begin
                    w_accept = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_EMIT;
                    end
                end else begin
                    w_state_nxt = S_EMIT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Next-term arithmetic; the k=0 step forwards seed1 and never overflows.
    always_comb begin
        w_sum       = {1'b0, r_term} + {1'b0, r_prev};
        w_carry     = w_sum[OUTPUT_WIDTH];
        w_next_term = w_sum[OUTPUT_WIDTH-1:0];
        w_next_ovf  = r_overflow;
        if (r_k == '0) begin
            w_next_term = r_prev;
        end else begin
            w_next_ovf = r_overflow | w_carry;
            if (w_carry && (SATURATE != 1'b0)) begin
                w_next_term = {OUTPUT_WIDTH{1'b1}};
            end else begin
                w_next_term = w_sum[OUTPUT_WIDTH-1:0];
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n          <= '0;
            r_k          <= '0;
            r_term       <= '0;
            r_prev       <= '0;
            r_term_valid <= 1'b0;
            r_result     <= '0;
            r_overflow   <= 1'b0;
            r_done       <= 1'b0;
        end else if (w_go_acc) begin
            r_n          <= i_n;
            r_k          <= '0;
            r_term       <= i_seed0;
            r_prev       <= i_seed1;
            r_term_valid <= 1'b1;
            r_overflow   <= 1'b0;
            r_done       <= 1'b0;
        end else if (w_accept) begin
            if (w_last) begin
                r_term_valid <= 1'b0;
                r_result     <= r_term;
                r_done       <= 1'b1;
            end else begin
                r_k          <= r_k + {{(INPUT_WIDTH-1){1'b0}}, 1'b1};
                r_term       <= w_next_term;
                r_prev       <= r_term;
                r_overflow   <= w_next_ovf;
            end
        end
    end

    assign o_term       = r_term;
    assign o_term_valid = r_term_valid;
    assign o_result     = r_result;
    assign o_overflow   = r_overflow;
    assign o_done       = r_done;

endmodule

// File: tb/tb_gfib_stream.sv
// Scoreboard bench for gfib_stream. Three instances run in lockstep on the
// same handshake: 32-bit wrap, 8-bit wrap and 8-bit saturate. Expected
// terms and end-of-run results come from a plain arithmetic model.
module tb_gfib_stream;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        go;
    logic        ready;
    logic [5:0]  n;
    logic [31:0] s0;
    logic [31:0] s1;

    logic [31:0] t32, r32;
    logic        v32, o32, d32;
    logic [7:0]  t8w, r8w, t8s, r8s;
    logic        v8w, o8w, d8w, v8s, o8s, d8s;

    gfib_stream #(.INPUT_WIDTH(6), .OUTPUT_WIDTH(32), .SATURATE(1'b0)) u_w32 (
        .clk(clk), .rst(rst), .i_go(go), .i_n(n), .i_seed0(s0), .i_seed1(s1),
        .o_term(t32), .o_term_valid(v32), .i_term_ready(ready),
        .o_result(r32), .o_overflow(o32), .o_done(d32));

    gfib_stream #(.INPUT_WIDTH(6), .OUTPUT_WIDTH(8), .SATURATE(1'b0)) u_w8 (
        .clk(clk), .rst(rst), .i_go(go), .i_n(n), .i_seed0(s0[7:0]), .i_seed1(s1[7:0]),
        .o_term(t8w), .o_term_valid(v8w), .i_term_ready(ready),
        .o_result(r8w), .o_overflow(o8w), .o_done(d8w));

    gfib_stream #(.INPUT_WIDTH(6), .OUTPUT_WIDTH(8), .SATURATE(1'b1)) u_s8 (
        .clk(clk), .rst(rst), .i_go(go), .i_n(n), .i_seed0(s0[7:0]), .i_seed1(s1[7:0]),
        .o_term(t8s), .o_term_valid(v8s), .i_term_ready(ready),
        .o_result(r8s), .o_overflow(o8s), .o_done(d8s));

    typedef struct {
        longint a;
        longint b;
        longint c;
    } trip_t;

    typedef struct {
        longint r32;
        longint o32;
        longint r8w;
        longint o8w;
        longint r8s;
        longint o8s;
    } done_t;

    trip_t  q_terms[$];
    done_t  q_done[$];

    int     errors = 0;
    int     checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // T(k) straight from the recurrence, w-bit terms, wrap or clamp.
    function automatic void model(input longint a0, input longint b0, input int w,
                                  input bit sat, input int k,
                                  output longint t, output bit ovf);
        longint mx;
        longint a;
        longint b;
        longint s;
        mx  = (longint'(1) << w) - 1;
        a   = a0 & mx;
        b   = b0 & mx;
        ovf = 1'b0;
        if (k == 0) begin
            t = a;
        end else begin
            for (int i = 2; i <= k; i++) begin
                s = a + b;
                if (s > mx) begin
                    ovf = 1'b1;
                    s   = sat ? mx : (s & mx);
                end
                a = b;
                b = s;
            end
            t = b;
        end
    endfunction

    task automatic push_expect(input int nn, input longint a, input longint b);
        trip_t  tr;
        done_t  dn;
        longint t;
        bit     ov;
        for (int k = 0; k <= nn; k++) begin
            model(a, b, 32, 1'b0, k, t, ov); tr.a = t;
            model(a, b, 8,  1'b0, k, t, ov); tr.b = t;
            model(a, b, 8,  1'b1, k, t, ov); tr.c = t;
            q_terms.push_back(tr);
        end
        model(a, b, 32, 1'b0, nn, t, ov); dn.r32 = t; dn.o32 = longint'(ov);
        model(a, b, 8,  1'b0, nn, t, ov); dn.r8w = t; dn.o8w = longint'(ov);
        model(a, b, 8,  1'b1, nn, t, ov); dn.r8s = t; dn.o8s = longint'(ov);
        q_done.push_back(dn);
    endtask

    // Monitor: compare accepted terms and end-of-run results, and check that
    // a stalled term holds its value.
    logic        d32_prev;
    logic        hold_pending;
    logic [31:0] held_t;
    always @(negedge clk) begin
        if (rst) begin
            d32_prev     <= 1'b0;
            hold_pending <= 1'b0;
        end else begin
            if (hold_pending && v32) begin
                chk("term_hold", longint'(t32), longint'(held_t));
            end
            hold_pending <= v32 && !ready;
            held_t       <= t32;
            if (v32 && ready) begin
                if (q_terms.size() == 0) begin
                    chk("unexpected_term", 1, 0);
                end else begin
                    trip_t e;
                    e = q_terms.pop_front();
                    chk("term32",   longint'(t32), e.a);
                    chk("term8w",   longint'(t8w), e.b);
                    chk("term8s",   longint'(t8s), e.c);
                    chk("valid8",   longint'({v8w, v8s}), 3);
                end
            end
            if (d32 && !d32_prev) begin
                if (q_done.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    done_t e;
                    e = q_done.pop_front();
                    chk("result32", longint'(r32), e.r32);
                    chk("ovf32",    longint'(o32), e.o32);
                    chk("result8w", longint'(r8w), e.r8w);
                    chk("ovf8w",    longint'(o8w), e.o8w);
                    chk("result8s", longint'(r8s), e.r8s);
                    chk("ovf8s",    longint'(o8s), e.o8s);
                    chk("done8",    longint'({d8w, d8s}), 3);
                    chk("valid_low", longint'(v32), 0);
                end
            end
            d32_prev <= d32;
        end
    end

    function automatic logic pick(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 2) == 0;
        return $urandom_range(0, 3) != 0;
    endfunction

    // One complete run; mode 0 ready high, 1 toggling, 2 random.
    task automatic run(input int nn, input longint a, input longint b,
                       input int mode, input bit glitch);
        int cyc;
        bit finished;
        push_expect(nn, a, b);
        n     = 6'(nn);
        s0    = 32'(a);
        s1    = 32'(b);
        go    = 1'b1;
        ready = pick(mode, 0);
        cyc   = 0;
        finished = 1'b0;
        while (!finished && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                go = 1'b0;
                chk("done_cleared", longint'(d32), 0);
                chk("valid_after_go", longint'(v32), 1);
            end
            if (d32) begin
                finished = 1'b1;
            end else begin
                ready = pick(mode, cyc);
                if (glitch && cyc == 3) begin
                    go = 1'b1;
                    n  = 6'($urandom);
                    s0 = $urandom;
                    s1 = $urandom;
                end
                if (glitch && cyc == 4) go = 1'b0;
            end
        end
        if (!finished) chk("done_timeout", 0, 1);
        if (mode == 0) chk("latency", cyc, nn + 2);
    endtask

    initial begin
        rst   = 1'b1;
        go    = 1'b0;
        ready = 1'b0;
        n     = 6'd0;
        s0    = 32'd0;
        s1    = 32'd0;
        #12;
        chk("rst_term",   longint'(t32), 0);
        chk("rst_valid",  longint'(v32), 0);
        chk("rst_result", longint'(r32), 0);
        chk("rst_ovf",    longint'(o32), 0);
        chk("rst_done",   longint'(d32), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run(10, 0, 1, 0, 1'b0);
        chk("fib10", longint'(r32), 55);
        chk("fib10_ovf", longint'(o32), 0);
        run(5, 2, 1, 1, 1'b0);
        chk("lucas5", longint'(r32), 11);
        run(0, 7, 9, 0, 1'b0);
        chk("n0", longint'(r32), 7);
        run(1, 7, 9, 2, 1'b0);
        chk("n1", longint'(r32), 9);
        run(13, 0, 1, 0, 1'b0);
        chk("w8_n13", longint'(r8w), 233);
        chk("w8_n13_ovf", longint'(o8w), 0);
        run(14, 0, 1, 0, 1'b0);
        chk("w8_n14", longint'(r8w), 121);
        chk("w8_n14_ovf", longint'(o8w), 1);
        chk("s8_n14", longint'(r8s), 255);
        chk("s8_n14_ovf", longint'(o8s), 1);
        run(3, 0, 1, 0, 1'b0);
        chk("ovf_cleared", longint'(o8w), 0);
        run(20, 3, 4, 0, 1'b1);
        run(9, 5, 8, 2, 1'b1);

        // Reset in the middle of a stream.
        push_expect(20, 0, 1);
        n     = 6'd20;
        s0    = 32'd0;
        s1    = 32'd1;
        go    = 1'b1;
        ready = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_term",   longint'(t32), 0);
        chk("mid_rst_valid",  longint'(v32), 0);
        chk("mid_rst_result", longint'(r32), 0);
        chk("mid_rst_ovf",    longint'(o32), 0);
        chk("mid_rst_done",   longint'(d32), 0);
        q_terms.delete();
        q_done.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run(3, 0, 1, 0, 1'b0);
        chk("after_rst", longint'(r32), 2);

        for (int i = 0; i < 30; i++) begin
            int     nn;
            longint a;
            longint b;
            nn = $urandom_range(0, 40);
            if ($urandom_range(0, 1) == 0) begin
                a = longint'($urandom_range(0, 20));
                b = longint'($urandom_range(0, 20));
            end else begin
                a = longint'($urandom);
                b = longint'($urandom);
            end
            run(nn, a, b, $urandom_range(0, 2),
                (nn >= 4) && ($urandom_range(0, 2) == 0));
        end

        repeat (3) @(negedge clk);
        chk("terms_left", q_terms.size(), 0);
        chk("done_left",  q_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
